uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one AXI4-Lite UART Lite core's TX path between N_REQ byte requesters.
//  - Round-robin arbitration between requesters.
//  - Reads STAT (0x8) and checks TX-FIFO-full before every write.
//  - Writes the granted byte to TX FIFO (0x4) and checks BRESP.
//  - Sits between producer blocks (ROM streamer, debug logger) and the UART core.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  ADDR_W    4   AXI address width
//  POLL_GAP  16  idle cycles between STAT reads while TX FIFO full (>=1)
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous reset, active-high
//  req_valid  in   N_REQ     per-requester byte valid
//  req_data   in   8*N_REQ   byte for requester i at [8i+7:8i]
//  req_ready  out  N_REQ     one-hot, 1-cycle pulse: byte i captured
//  awaddr     out  ADDR_W    write address
//  awvalid    out  1         write address valid
//  awready    in   1         write address ready
//  wdata      out  8         write data (core sees {24'h0,wdata}, wstrb=4'hf)
//  wvalid     out  1         write data valid
//  wready     in   1         write data ready
//  bresp      in   2         write response
//  bvalid     in   1         write response valid
//  bready     out  1         write response ready
//  araddr     out  ADDR_W    read address
//  arvalid    out  1         read address valid
//  arready    in   1         read address ready
//  rdata      in   8         read data (low byte of STAT)
//  rvalid     in   1         read data valid
//  rready     out  1         read data ready
//  err        out  1         sticky: any BRESP/RRESP-equivalent != 2'b00 seen on bresp
// BEHAVIOUR
//  Reset outputs: all valid/ready 0, awaddr=araddr=0, wdata=0, err=0; rr pointer=0.
//  State machine:
//    IDLE -> POLL_AR when any req_valid
//    POLL_AR -> POLL_R on arvalid&arready; araddr=0x8
//    POLL_R (rready=1) on rvalid:
//      rdata[3]=1 (full) -> WAIT
//      rdata[3]=0 -> GRANT
//    WAIT: count POLL_GAP cycles -> POLL_AR
//    GRANT: 1 cycle. Pick first valid requester at/after rr pointer; latch its byte;
//      pulse req_ready[i]; rr pointer <= i+1 (mod N_REQ).
//      If no req_valid (requester withdrew) -> IDLE, no write issued.
//    WR: awvalid=wvalid=1, awaddr=0x4.
//      - Each valid drops independently on its own handshake.
//      - -> RESP when both handshakes done (same or different cycles).
//    RESP: bready=1; on bvalid -> IDLE; bresp!=0 sets err.
//  Handshakes: valid never drops before ready; address/data stable while valid.
//  Latency: idle request to awvalid = 4 cycles with zero-wait AXI slave and FIFO not full.
//  Throughput: at most one byte per poll+write transaction. No byte dropped or duplicated.
//  Simultaneous requests: served strictly round-robin; no requester starved beyond N_REQ-1 grants.
//  rst mid-transaction: immediate return to reset state; partial AXI transaction abandoned.
//    The UART core is reset by the same rst, so nothing stays outstanding.
// CONFIGURATION
//  UART_FIFO_RST_EN defined:
//    - After reset, state INIT writes 0x03 to CTRL (0xC): clears TX+RX FIFOs.
//    - Uses WR/RESP sequencing, then IDLE.
//    - req_ready stays 0 until INIT completes.
//  Undefined: no INIT state; IDLE directly after reset.
// TESTING
//  1. req_valid=4'b0001, data 0x41, zero-wait slave, STAT=0x00
//     -> one AR@0x8, one AW@0x4 with wdata=0x41, req_ready[0] pulses once.
//  2. All 4 valid, bytes 0x10..0x13, 8 grants
//     -> write order 0x10,0x11,0x12,0x13,0x10,... (round-robin from 0).
//  3. STAT returns 0x08 three times, then 0x00
//     -> 3 polls spaced POLL_GAP idle cycles apart, then exactly one write.
//  4. Slave asserts wready 3 cycles before awready
//     -> wvalid drops after its handshake, awvalid held, single B phase.
//  5. bresp=2'b10 -> err=1 and stays 1. Assert rst during WR -> all outputs at reset values next cycle.
//  6. With UART_FIFO_RST_EN defined
//     -> first AXI write after reset is 0x03 to 0xC; req_ready 0 until its B phase completes.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite UART Lite TX FIFO between N_REQ byte sources.
// Define UART_FIFO_RST_EN to clear the core FIFOs (CTRL=0x03) once after reset.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 4,
  parameter int POLL_GAP = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [ADDR_W-1:0]    awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [7:0]           wdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [ADDR_W-1:0]    araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [7:0]           rdata,
  input  logic                 rvalid,
  output logic                 rready,
  output logic                 err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_AR,
    S_POLL_R,
    S_WAIT,
    S_GRANT,
    S_WR,
    S_RESP
`ifdef UART_FIFO_RST_EN
    , S_INIT
`endif
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [IW:0]   sum;
  logic          found;
  logic [7:0]    tx_byte;
  logic          aw_done;
  logic          w_done;
  logic [CW-1:0] cnt;
  logic          err_seen;
  logic          ctrl_wr;
  logic          unused_rdata;

  assign unused_rdata = ^{rdata[7:4], rdata[2:0]};

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    gidx  = ptr;
    sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ))
        sum = sum - (IW+1)'(N_REQ);
      if (req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        gidx  = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef UART_FIFO_RST_EN
      state   <= S_INIT;
      ctrl_wr <= 1'b1;
`else
      state   <= S_IDLE;
      ctrl_wr <= 1'b0;
`endif
      ptr      <= '0;
      tx_byte  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      cnt      <= '0;
      err_seen <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_GRANT && found) begin
        tx_byte <= req_data[8*gidx +: 8];
        ptr     <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      end
`ifdef UART_FIFO_RST_EN
      if (state == S_INIT)
        tx_byte <= 8'h03;
`endif
      if (state == S_WR) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      cnt <= (state == S_WAIT) ? cnt + 1'b1 : '0;
      if (state == S_RESP && bvalid) begin
        ctrl_wr <= 1'b0;
        if (bresp != 2'b00) err_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (|req_valid) nxt = S_POLL_AR;
      S_POLL_AR: if (arready) nxt = S_POLL_R;
      S_POLL_R:  if (rvalid) nxt = rdata[3] ? S_WAIT : S_GRANT;
      S_WAIT:    if (cnt == CW'(POLL_GAP - 1)) nxt = S_POLL_AR;
      S_GRANT:   nxt = found ? S_WR : S_IDLE;
      S_WR:      if ((aw_done || awready) && (w_done || wready)) nxt = S_RESP;
      S_RESP:    if (bvalid) nxt = S_IDLE;
`ifdef UART_FIFO_RST_EN
      S_INIT:    nxt = S_WR;
`endif
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    awaddr    = '0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    araddr    = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    unique case (state)
      S_POLL_AR: begin
        arvalid = 1'b1;
        araddr  = ADDR_W'(8);
      end
      S_POLL_R: rready = 1'b1;
      S_GRANT:  req_ready[gidx] = found;
      S_WR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        awaddr  = ctrl_wr ? ADDR_W'(12) : ADDR_W'(4);
      end
      S_RESP:   bready = 1'b1;
      default: ;
    endcase
  end

  assign wdata = tx_byte;
  assign err   = err_seen;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reactive AXI-Lite slave + byte sources,
// vector table plus latency, round-robin, poll-gap, sticky-err and reset sequences.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [3:0]     awaddr;
  logic           awvalid;
  logic           awready = 1'b0;
  logic [7:0]     wdata;
  logic           wvalid;
  logic           wready = 1'b0;
  logic [1:0]     bresp = 2'b00;
  logic           bvalid = 1'b0;
  logic           bready;
  logic [3:0]     araddr;
  logic           arvalid;
  logic           arready = 1'b0;
  logic [7:0]     rdata = 8'h00;
  logic           rvalid = 1'b0;
  logic           rready;
  logic           err;

  uart_tx_arbiter #(.N_REQ(N), .ADDR_W(4), .POLL_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          cnt;
    int          full;
    int          awd;
    int          wd;
    logic [1:0]  br;
    int          e_ar;
    int          e_aw;
    logic        e_err;
    logic [7:0]  e_last;
  } vec_t;

  vec_t vt[7];

  int          cyc = 0;
  int          rq_total[N];
  int          gnt_n[N];
  logic [31:0] rq_data = '0;
  int          full_left = 0;
  int          aw_dly = 0;
  int          w_dly = 0;
  logic [1:0]  br_cfg = 2'b00;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  int          ar_n, aw_n, w_n, b_n, bad;
  int          ar_cyc[$];
  logic [3:0]  aw_q[$];
  logic [7:0]  w_q[$];
  int          first_req, first_aw;
  logic        aw_hold, w_hold;
  logic [3:0]  aw_hold_a;
  logic [7:0]  w_hold_d;
  int          pass_n = 0;
  int          chk_n = 0;

  // Slave and requester drive, 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (rst) begin
      req_valid = '0;
      req_data  = '0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      aw_cnt    = 0;
      w_cnt     = 0;
    end else begin
      for (int i = 0; i < N; i++)
        req_valid[i] = gnt_n[i] < rq_total[i];
      req_data = rq_data;
      if (req_valid != 0 && first_req < 0) first_req = cyc;
      arready = 1'b1;
      rvalid  = rready;
      if (rready) begin
        rdata = (full_left > 0) ? 8'h08 : 8'h00;
        if (full_left > 0) full_left--;
      end
      if (awvalid) begin
        awready = aw_cnt >= aw_dly;
        aw_cnt++;
      end else begin
        awready = 1'b0;
        aw_cnt  = 0;
      end
      if (wvalid) begin
        wready = w_cnt >= w_dly;
        w_cnt++;
      end else begin
        wready = 1'b0;
        w_cnt  = 0;
      end
      bvalid = bready;
      bresp  = br_cfg;
    end
  end

  // Monitor: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        ar_n++;
        ar_cyc.push_back(cyc);
        if (araddr != 4'h8) bad++;
      end
      if (awvalid && awready) begin
        aw_n++;
        aw_q.push_back(awaddr);
        if (awaddr != 4'h4) bad++;
      end
      if (wvalid && wready) begin
        w_n++;
        w_q.push_back(wdata);
      end
      if (bvalid && bready) b_n++;
      if (req_ready != 0) begin
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != 0) bad++;
        for (int i = 0; i < N; i++)
          if (req_ready[i]) gnt_n[i]++;
      end
      if (aw_hold && (!awvalid || awaddr != aw_hold_a)) bad++;
      if (w_hold && (!wvalid || wdata != w_hold_d)) bad++;
      aw_hold   = awvalid && !awready;
      aw_hold_a = awaddr;
      w_hold    = wvalid && !wready;
      w_hold_d  = wdata;
      if (awvalid && first_aw < 0) first_aw = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic clear_logs();
    ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; bad = 0;
    ar_cyc.delete(); aw_q.delete(); w_q.delete();
    for (int i = 0; i < N; i++) begin
      rq_total[i] = 0;
      gnt_n[i]    = 0;
    end
    first_req = -1; first_aw = -1;
    aw_hold = 1'b0; w_hold = 1'b0;
  endtask

  function automatic logic [31:0] out_vec();
    return {6'd0, awvalid, wvalid, bready, arvalid, rready, req_ready,
            awaddr, araddr, wdata, err};
  endfunction

  task automatic do_reset();
    int t;
    rst = 1'b1;
    clear_logs();
    full_left = 0; aw_dly = 0; w_dly = 0; br_cfg = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef UART_FIFO_RST_EN
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (b_n >= 1) break;
    end
    chk("init_b_done", 32'(t < 100), 1);
    chk("init_awaddr", 32'(aw_q.size() > 0 ? aw_q[0] : 4'hx), 32'hc);
    chk("init_wdata", 32'(w_q.size() > 0 ? w_q[0] : 8'hxx), 32'h03);
    repeat (3) @(negedge clk);
    clear_logs();
`else
    t = 0;
`endif
  endtask

  task automatic run(input string nm);
    int t;
    bit done;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < N; i++)
        if (gnt_n[i] < rq_total[i]) done = 1'b0;
      if (done) break;
    end
    chk({nm, "_done"}, 32'(t < 3000), 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic load(input vec_t v);
    full_left = v.full;
    aw_dly    = v.awd;
    w_dly     = v.wd;
    br_cfg    = v.br;
    rq_data   = v.data;
    for (int i = 0; i < N; i++)
      rq_total[i] = v.mask[i] ? v.cnt : 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vec_t v;
    vt[0] = '{4'b0001, 32'h00000041, 1, 0, 0, 0, 2'b00, 1, 1, 1'b0, 8'h41};
    vt[1] = '{4'b1111, 32'h13121110, 2, 0, 0, 0, 2'b00, 8, 8, 1'b0, 8'h13};
    vt[2] = '{4'b0001, 32'h00000055, 1, 3, 0, 0, 2'b00, 4, 1, 1'b0, 8'h55};
    vt[3] = '{4'b0100, 32'h00770000, 1, 0, 3, 0, 2'b00, 1, 1, 1'b0, 8'h77};
    vt[4] = '{4'b0010, 32'h00005a00, 1, 0, 0, 0, 2'b10, 1, 1, 1'b1, 8'h5a};
    vt[5] = '{4'b1000, 32'ha5000000, 3, 0, 0, 2, 2'b00, 3, 3, 1'b0, 8'ha5};
    vt[6] = '{4'b0101, 32'h00220011, 2, 1, 1, 1, 2'b00, 5, 4, 1'b0, 8'h22};

    rst = 1'b1;
    clear_logs();
    repeat (2) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);

    for (int n = 0; n < 7; n++) begin
      v = vt[n];
      do_reset();
      load(v);
      run($sformatf("v%0d", n));
      chk($sformatf("v%0d_ar", n), ar_n, v.e_ar);
      chk($sformatf("v%0d_aw", n), aw_n, v.e_aw);
      chk($sformatf("v%0d_w", n), w_n, v.e_aw);
      chk($sformatf("v%0d_b", n), b_n, v.e_aw);
      chk($sformatf("v%0d_err", n), 32'(err), 32'(v.e_err));
      chk($sformatf("v%0d_last", n),
          32'(w_q.size() > 0 ? w_q[w_q.size()-1] : 8'hxx), 32'(v.e_last));
      chk($sformatf("v%0d_protocol", n), bad, 0);
    end

    do_reset();
    rq_data = 32'h41;
    rq_total[0] = 1;
    run("lat");
    chk("latency_req_to_awvalid", first_aw - first_req, 4);

    do_reset();
    rq_data = 32'h13121110;
    for (int i = 0; i < N; i++) rq_total[i] = 2;
    run("rr");
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_order%0d", k),
          32'(w_q.size() > k ? w_q[k] : 8'hxx), 32'h10 + 32'(k % 4));

    do_reset();
    full_left = 3;
    rq_data = 32'h55;
    rq_total[0] = 1;
    run("poll");
    chk("poll_writes", w_n, 1);
    for (int k = 1; k < 4; k++)
      chk($sformatf("poll_gap%0d", k),
          ar_cyc.size() > k ? ar_cyc[k] - ar_cyc[k-1] : -1, GAP + 2);

    do_reset();
    br_cfg = 2'b10;
    rq_data = 32'h33;
    rq_total[0] = 1;
    run("err1");
    chk("err_set", 32'(err), 1);
    br_cfg = 2'b00;
    rq_total[0] = 2;
    run("err2");
    chk("err_sticky", 32'(err), 1);
    chk("err_b_count", b_n, 2);
    aw_dly = 50;
    rq_total[0] = 3;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (awvalid) break;
    end
    chk("midwr_reached", 32'(t < 300), 1);
    rst = 1'b1;
    #1;
    chk("midwr_reset_outputs", out_vec(), 0);
    @(negedge clk);
    chk("midwr_reset_hold", out_vec(), 0);
    aw_dly = 0;
    ar_n = 0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midwr_no_retry", ar_n, 0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
